// File: rtl/note_slot_scheduler.sv
// note_slot_scheduler: 32-entry note slot table with spawn/retire allocation and a back-pressured per-frame scan
// ports: clk_in/rst (sync, active-high); scan_en starts scan frames; spawn_valid/spawn_x/spawn_ready allocate the lowest free slot;
//        retire_valid/retire_idx free a slot; slot_valid/slot_idx/slot_x/slot_ready present active slots; frame_done pulses per frame;
//        active_count is the number of occupied slots
module note_slot_scheduler #(
  parameter int NUM_SLOTS = 32,
  parameter int XW = 10,
  parameter int IDXW = 5
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            scan_en,
  input  logic            spawn_valid,
  input  logic [XW-1:0]   spawn_x,
  output logic            spawn_ready,
  input  logic            retire_valid,
  input  logic [IDXW-1:0] retire_idx,
  output logic            slot_valid,
  output logic [IDXW-1:0] slot_idx,
  output logic [XW-1:0]   slot_x,
  input  logic            slot_ready,
  output logic            frame_done,
  output logic [IDXW:0]   active_count
);
  typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;
  state_t state;
  logic [NUM_SLOTS-1:0] active;
  logic [XW-1:0] x [NUM_SLOTS];
  logic [IDXW-1:0] scan_idx, free_idx;
  logic [NUM_SLOTS-1:0] ret_mask, spn_mask;
  logic spawn_acc, retire_eff, last;
  assign spawn_ready = ~&active;
  assign spawn_acc = spawn_valid & spawn_ready;
  assign retire_eff = retire_valid & active[retire_idx];
  assign last = &scan_idx;
  // allocator sees pre-retire occupancy, so a slot retired this cycle is never reused this cycle
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!active[i]) free_idx = IDXW'(i);
  end
  assign ret_mask = NUM_SLOTS'(retire_eff) << retire_idx;
  assign spn_mask = NUM_SLOTS'(spawn_acc) << free_idx;
  always_ff @(posedge clk_in)
    if (spawn_acc) x[free_idx] <= spawn_x;
  always_ff @(posedge clk_in) begin
    frame_done <= 1'b0;
    if (rst) begin
      active <= '0;
      active_count <= '0;
      state <= IDLE;
      scan_idx <= '0;
      slot_valid <= 1'b0;
      slot_idx <= '0;
      slot_x <= '0;
    end else begin
      active <= (active & ~ret_mask) | spn_mask;
      active_count <= active_count + (IDXW+1)'(spawn_acc) - (IDXW+1)'(retire_eff);
      case (state)
        IDLE: if (scan_en) begin
          state <= SCAN;
          scan_idx <= '0;
        end
        SCAN: if (active[scan_idx]) begin
          slot_idx <= scan_idx;
          slot_x <= x[scan_idx];
          slot_valid <= 1'b1;
          state <= WAIT;
        end else if (last) begin
          frame_done <= 1'b1;
          scan_idx <= '0;
          state <= scan_en ? SCAN : IDLE;
        end else scan_idx <= scan_idx + IDXW'(1);
        WAIT: if (slot_ready) begin
          slot_valid <= 1'b0;
          frame_done <= last;
          scan_idx <= last ? '0 : scan_idx + IDXW'(1);
          state <= (last && !scan_en) ? IDLE : SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_slot_scheduler.sv
// tb_note_slot_scheduler: directed checks of allocation, retire, scan sequencing, backpressure and reset
module tb_note_slot_scheduler;
  logic clk_in = 0, rst = 1, scan_en = 0, spawn_valid = 0, retire_valid = 0, slot_ready = 0;
  logic [9:0] spawn_x = '0;
  logic [4:0] retire_idx = '0;
  logic spawn_ready, slot_valid, frame_done;
  logic [4:0] slot_idx;
  logic [9:0] slot_x;
  logic [5:0] active_count;
  int n_chk = 0, n_fail = 0;
  int nt, fd_at, fd_n;
  int exp_x [32];
  note_slot_scheduler dut (
    .clk_in(clk_in), .rst(rst), .scan_en(scan_en), .spawn_valid(spawn_valid), .spawn_x(spawn_x),
    .spawn_ready(spawn_ready), .retire_valid(retire_valid), .retire_idx(retire_idx),
    .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_x(slot_x), .slot_ready(slot_ready),
    .frame_done(frame_done), .active_count(active_count)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    chk("rst_valid", 32'(slot_valid), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_count", 32'(active_count), 0);
    chk("rst_ready", 32'(spawn_ready), 1);
    spawn_valid = 1;
    spawn_x = 100;
    tick;
    spawn_x = 200;
    tick;
    spawn_x = 300;
    tick;
    spawn_valid = 0;
    chk("count3", 32'(active_count), 3);
    scan_en = 1;
    slot_ready = 1;
    tick;
    nt = 0;
    fd_at = -1;
    fd_n = 0;
    for (int c = 0; c < 36; c++) begin
      if (slot_valid && slot_ready) begin
        chk("f1_idx", 32'(slot_idx), 32'(nt));
        chk("f1_x", 32'(slot_x), 32'(100 * (nt + 1)));
        nt++;
      end
      if (frame_done) begin
        fd_n++;
        if (fd_at < 0) fd_at = c;
      end
      tick;
    end
    chk("f1_xfers", 32'(nt), 3);
    chk("f1_fd_at", 32'(fd_at), 35);
    chk("f1_fd_n", 32'(fd_n), 1);
    tick;
    tick;
    chk("bp_valid0", 32'(slot_valid), 1);
    chk("bp_idx0", 32'(slot_idx), 1);
    chk("bp_x0", 32'(slot_x), 200);
    slot_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", 32'(slot_valid), 1);
      chk("bp_idx", 32'(slot_idx), 1);
      chk("bp_x", 32'(slot_x), 200);
    end
    slot_ready = 1;
    tick;
    chk("bp_release", 32'(slot_valid), 0);
    tick;
    chk("bp_next_idx", 32'(slot_idx), 2);
    chk("bp_next_x", 32'(slot_x), 300);
    scan_en = 0;
    fd_n = 0;
    for (int i = 0; i < 40 && fd_n == 0; i++) begin
      tick;
      if (frame_done) fd_n++;
    end
    chk("stop_fd", 32'(fd_n), 1);
    tick;
    tick;
    chk("idle_valid", 32'(slot_valid), 0);
    chk("idle_fd", 32'(frame_done), 0);
    rst = 1;
    tick;
    rst = 0;
    spawn_valid = 1;
    for (int i = 0; i < 32; i++) begin
      spawn_x = 10'(i);
      exp_x[i] = i;
      tick;
    end
    chk("full_count", 32'(active_count), 32);
    chk("full_ready", 32'(spawn_ready), 0);
    spawn_x = 999;
    tick;
    spawn_valid = 0;
    chk("ovf_count", 32'(active_count), 32);
    retire_valid = 1;
    retire_idx = 5;
    tick;
    retire_valid = 0;
    chk("ret5_count", 32'(active_count), 31);
    chk("ret5_ready", 32'(spawn_ready), 1);
    spawn_valid = 1;
    spawn_x = 777;
    exp_x[5] = 777;
    tick;
    spawn_valid = 0;
    chk("sp777_count", 32'(active_count), 32);
    retire_valid = 1;
    retire_idx = 7;
    tick;
    chk("ret7_count", 32'(active_count), 31);
    retire_idx = 3;
    spawn_valid = 1;
    spawn_x = 555;
    exp_x[7] = 555;
    tick;
    spawn_valid = 0;
    chk("both_count", 32'(active_count), 31);
    chk("both_ready", 32'(spawn_ready), 1);
    tick;
    retire_valid = 0;
    chk("ret_inactive", 32'(active_count), 31);
    spawn_valid = 1;
    spawn_x = 333;
    exp_x[3] = 333;
    tick;
    spawn_valid = 0;
    chk("sp333_count", 32'(active_count), 32);
    scan_en = 1;
    slot_ready = 1;
    tick;
    nt = 0;
    fd_at = -1;
    for (int c = 0; c < 65; c++) begin
      if (slot_valid && slot_ready) begin
        chk("f2_idx", 32'(slot_idx), 32'(nt));
        chk("f2_x", 32'(slot_x), 32'(exp_x[nt]));
        nt++;
      end
      if (frame_done && fd_at < 0) fd_at = c;
      tick;
    end
    chk("f2_xfers", 32'(nt), 32);
    chk("f2_fd_at", 32'(fd_at), 64);
    slot_ready = 0;
    for (int i = 0; i < 5 && !slot_valid; i++) tick;
    chk("wait_valid", 32'(slot_valid), 1);
    rst = 1;
    scan_en = 0;
    tick;
    rst = 0;
    chk("wrst_valid", 32'(slot_valid), 0);
    chk("wrst_count", 32'(active_count), 0);
    chk("wrst_ready", 32'(spawn_ready), 1);
    tick;
    chk("wrst_idle", 32'(slot_valid), 0);
    scan_en = 1;
    slot_ready = 1;
    tick;
    fd_at = -1;
    fd_n = 0;
    nt = 0;
    for (int c = 0; c < 33; c++) begin
      if (slot_valid) nt++;
      if (frame_done) begin
        fd_n++;
        if (fd_at < 0) fd_at = c;
      end
      tick;
    end
    scan_en = 0;
    chk("empty_presented", 32'(nt), 0);
    chk("empty_fd_at", 32'(fd_at), 32);
    chk("empty_fd_n", 32'(fd_n), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
